pipe_adder: RTL and testbench

Parametrised, pipelined ripple-segment adder: the next generation of the team's fixed 4-bit adder. It adds two WIDTH-bit operands plus carry-in, one SEG_W-bit segment per pipeline stage, with the carry registered between stages. It accepts one operation per cycle through a valid/ready handshake with full backpressure. It sits in the datapath wherever wide additions must close timing at clock rate.

---
 rtl/adder_pkg.sv | 22 ++
 rtl/adder_seg.sv | 38 +++
 rtl/pipe_adder.sv | 180 ++++++++++++++++++
 tb/tb_pipe_adder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the pipelined segment adder.
//   DEFAULT_WIDTH / DEFAULT_SEG_W : default operand width and bits per stage.
//   seg_count(width, seg_w)       : number of pipeline stages for a given split.
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_SEG_W = 4;

    // Stage count for a width/segment split. A zero segment width returns
    // a single stage so that the bad configuration is caught by the
    // divisibility check in the top rather than by a divide-by-zero.
    function automatic int seg_count(input int width, input int seg_w);
        if (seg_w <= 0) begin
            return 1;
        end
        return width / seg_w;
    endfunction

endpackage : adder_pkg

// File: rtl/adder_seg.sv
// -----------------------------------------------------------------------------
// adder_seg
// Purely combinational SEG_W-bit ripple-carry segment.
// Ports:
//   a, b   in  SEG_W  operand slices
//   ci     in  1      carry into bit 0
//   s      out SEG_W  slice sum
//   co     out 1      carry out of the top bit
//   c_msb  out 1      carry into the top bit (signed-overflow detection)
// -----------------------------------------------------------------------------
module adder_seg #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             ci,
    output logic [SEG_W-1:0] s,
    output logic             co,
    output logic             c_msb
);

    // w_c[i] is the carry into bit i; w_c[SEG_W] is the carry out.
    logic [SEG_W:0] w_c;

    assign w_c[0] = ci;

    genvar gi;
    generate
        for (gi = 0; gi < SEG_W; gi++) begin : g_bit
            assign s[gi]     = a[gi] ^ b[gi] ^ w_c[gi];
            assign w_c[gi+1] = (a[gi] & b[gi]) | (a[gi] & w_c[gi]) | (b[gi] & w_c[gi]);
        end
    endgenerate

    assign co    = w_c[SEG_W];
    assign c_msb = w_c[SEG_W-1];

endmodule : adder_seg

// File: rtl/pipe_adder.sv
// -----------------------------------------------------------------------------
// pipe_adder
// Pipelined ripple-segment adder: sum = a + b + cin (mod 2^WIDTH), one SEG_W
// slice per stage, carry registered between stages. Latency NSEG cycles,
// one operation per cycle, valid/ready handshake with a global stall.
//
// Optional feature macro: PIPE_ADDER_OVF_EN adds the registered signed
// overflow output ovf.
//
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      asynchronous active-high reset
//   in_valid   in  1      operands present
//   in_ready   out 1      block can accept this cycle
//   a, b       in  WIDTH  operands
//   cin        in  1      carry-in
//   out_valid  out 1      result present
//   out_ready  in  1      downstream accepts result
//   sum        out WIDTH  result
//   cout       out 1      carry out of the MSB
//   ovf        out 1      signed overflow (PIPE_ADDER_OVF_EN only)
// -----------------------------------------------------------------------------
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEG_W = DEFAULT_SEG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSEG = seg_count(WIDTH, SEG_W);

    generate
        if ((SEG_W <= 0) || ((WIDTH % SEG_W) != 0)) begin : g_bad_cfg
            $error("pipe_adder: WIDTH (%0d) must be a multiple of SEG_W (%0d)", WIDTH, SEG_W);
        end
    endgenerate

    // Single global enable: the whole pipe moves or the whole pipe holds.
    logic w_en;
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    genvar gi;
    generate
        for (gi = 0; gi < NSEG; gi++) begin : g_stage
            // Result bits accumulated up to and including this stage.
            localparam int LO_W = (gi + 1) * SEG_W;

            logic [SEG_W-1:0] w_a;
            logic [SEG_W-1:0] w_b;
            logic             w_ci;
            logic [SEG_W-1:0] w_s;
            logic             w_co;
            logic             w_cmsb;
            logic             w_unused_cmsb;

            logic [LO_W-1:0]  r_s;
            logic             r_c;
            logic             r_v;

            adder_seg #(
                .SEG_W (SEG_W)
            ) u_seg (
                .a     (w_a),
                .b     (w_b),
                .ci    (w_ci),
                .s     (w_s),
                .co    (w_co),
                .c_msb (w_cmsb)
            );

            // Only the last stage's top-bit carry feeds overflow detection.
            assign w_unused_cmsb = w_cmsb;

            if (gi == 0) begin : g_first
                assign w_a  = a[SEG_W-1:0];
                assign w_b  = b[SEG_W-1:0];
                assign w_ci = cin;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_s <= '0;
                        r_c <= 1'b0;
                        r_v <= 1'b0;
                    end else if (w_en) begin
                        r_s <= w_s;
                        r_c <= w_co;
                        r_v <= in_valid;
                    end
                end
            end else begin : g_next
                // Operand slice arrives through the skew chain in step with
                // the carry registered by the previous stage.
                assign w_a  = g_stage[gi-1].g_skew.r_a_hi[SEG_W-1:0];
                assign w_b  = g_stage[gi-1].g_skew.r_b_hi[SEG_W-1:0];
                assign w_ci = g_stage[gi-1].r_c;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_s <= '0;
                        r_c <= 1'b0;
                        r_v <= 1'b0;
                    end else if (w_en) begin
                        // Lower result slices ride along (deskew) with the new one.
                        r_s <= {w_s, g_stage[gi-1].r_s};
                        r_c <= w_co;
                        r_v <= g_stage[gi-1].r_v;
                    end
                end
            end

            // Operand bits not yet consumed travel down the pipe; each stage
            // peels off its lowest SEG_W bits. The last stage needs none.
            if (gi < NSEG - 1) begin : g_skew
                localparam int HI_W = WIDTH - LO_W;

                logic [HI_W-1:0] w_a_src;
                logic [HI_W-1:0] w_b_src;
                logic [HI_W-1:0] r_a_hi;
                logic [HI_W-1:0] r_b_hi;

                if (gi == 0) begin : g_src_in
                    assign w_a_src = a[WIDTH-1:SEG_W];
                    assign w_b_src = b[WIDTH-1:SEG_W];
                end else begin : g_src_prev
                    assign w_a_src = g_stage[gi-1].g_skew.r_a_hi[HI_W+SEG_W-1:SEG_W];
                    assign w_b_src = g_stage[gi-1].g_skew.r_b_hi[HI_W+SEG_W-1:SEG_W];
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_a_hi <= '0;
                        r_b_hi <= '0;
                    end else if (w_en) begin
                        r_a_hi <= w_a_src;
                        r_b_hi <= w_b_src;
                    end
                end
            end
        end
    endgenerate

    // Outputs come straight from the last stage registers.
    assign out_valid = g_stage[NSEG-1].r_v;
    assign sum       = g_stage[NSEG-1].r_s;
    assign cout      = g_stage[NSEG-1].r_c;

`ifdef PIPE_ADDER_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    // Registered alongside the last segment so it stays aligned with sum.
    logic r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_en) begin
            r_ovf <= g_stage[NSEG-1].w_cmsb ^ g_stage[NSEG-1].w_co;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule : pipe_adder

// File: tb/tb_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_adder
// Directed bench for pipe_adder at default parameters (WIDTH=16, SEG_W=4).
// A queue-based reference computes a+b+cin for every accepted operation and a
// negedge scoreboard checks every output transfer, the ready rule and output
// stability during stalls. Directed tasks pin latency and literal results.
// -----------------------------------------------------------------------------
module tb_pipe_adder;

    localparam int W   = 16;
    localparam int LAT = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
`ifdef PIPE_ADDER_OVF_EN
    logic          ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pipe_adder #(
        .WIDTH (16),
        .SEG_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PIPE_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t          exp_q[$];
    logic [W-1:0]  got_log[$];
    logic          stall_prev = 1'b0;
    logic [W-1:0]  prev_sum;
    logic          prev_cout;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
            if (stall_prev) begin
                chk("stall_valid_hold", {31'd0, out_valid}, 32'd1);
                chk("stall_sum_hold",   {16'd0, sum},       {16'd0, prev_sum});
                chk("stall_cout_hold",  {31'd0, cout},      {31'd0, prev_cout});
            end
            if (out_valid && exp_q.size() == 0) begin
                chk("spurious_out_valid", 32'd1, 32'd0);
            end else if (out_valid && out_ready) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_sum",  {16'd0, sum},  {16'd0, e.s});
                chk("sb_cout", {31'd0, cout}, {31'd0, e.c});
`ifdef PIPE_ADDER_OVF_EN
                chk("sb_ovf",  {31'd0, ovf},  {31'd0, e.o});
`endif
                got_log.push_back(sum);
                $display("[TB] out sum=%h cout=%b", sum, cout);
            end
            if (in_valid && in_ready) begin
                exp_t e;
                logic [W:0] full;
                full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                e.s  = full[W-1:0];
                e.c  = full[W];
                // Signed overflow: like-signed operands yield an opposite-signed result.
                e.o  = (a[W-1] == b[W-1]) && (e.s[W-1] != a[W-1]);
                exp_q.push_back(e);
                $display("[TB] in  a=%h b=%h cin=%b", a, b, cin);
            end
            stall_prev = out_valid && !out_ready;
            prev_sum   = sum;
            prev_cout  = cout;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at posedge+1; returns at posedge+1 right after the transfer edge.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        cin      = cv;
        for (int t = 0; t < 100; t++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    // Issued op must appear exactly LAT edges after its transfer, for one cycle.
    task automatic check_latency(input string nm, input logic [W-1:0] es,
                                 input logic ec, input logic eo);
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            chk({nm, "_valid"}, {31'd0, out_valid}, {31'd0, (k == LAT)});
            if (k == LAT) begin
                chk({nm, "_sum"},  {16'd0, sum},  {16'd0, es});
                chk({nm, "_cout"}, {31'd0, cout}, {31'd0, ec});
`ifdef PIPE_ADDER_OVF_EN
                chk({nm, "_ovf"},  {31'd0, ovf},  {31'd0, eo});
`else
                if (eo) begin end
`endif
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] stream_exp [4];

    initial begin
        bit seen;
        rst       = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;

        // Reset asserted mid-clock; outputs must clear without a clock edge.
        #3 rst = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum",       {16'd0, sum},       32'd0);
        chk("rst_cout",      {31'd0, cout},      32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
`ifdef PIPE_ADDER_OVF_EN
        chk("rst_ovf",       {31'd0, ovf},       32'd0);
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Basic single beat.
        send(16'h000F, 16'h0001, 1'b0);
        check_latency("basic", 16'h0010, 1'b0, 1'b0);

        // Full carry chain through every stage.
        send(16'hFFFF, 16'h0000, 1'b1);
        check_latency("carry_chain", 16'h0000, 1'b1, 1'b0);

        send(16'hFFFF, 16'h0001, 1'b0);
        check_latency("wrap", 16'h0000, 1'b1, 1'b0);

        send(16'h7FFF, 16'h0001, 1'b0);
        check_latency("pos_ovf", 16'h8000, 1'b0, 1'b1);

        send(16'h8000, 16'hFFFF, 1'b0);
        check_latency("neg_ovf", 16'h7FFF, 1'b1, 1'b1);

        send(16'h1234, 16'h4321, 1'b1);
        check_latency("mixed", 16'h5556, 1'b0, 1'b0);

        // Streaming with backpressure.
        @(posedge clk);
        #1;
        got_log.delete();
        stream_exp[0] = 16'h0002;
        stream_exp[1] = 16'h0020;
        stream_exp[2] = 16'h0200;
        stream_exp[3] = 16'h2000;
        send(16'h0001, 16'h0001, 1'b0);
        send(16'h0010, 16'h0010, 1'b0);
        send(16'h0100, 16'h0100, 1'b0);
        send(16'h1000, 16'h1000, 1'b0);
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("stream_first_seen", {31'd0, seen}, 32'd1);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_sum",      {16'd0, sum},      {16'd0, stream_exp[0]});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int t = 0; t < 30 && got_log.size() < 4; t++) @(posedge clk);
        chk("stream_count", got_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_log.size()) chk("stream_order", {16'd0, got_log[i]}, {16'd0, stream_exp[i]});
        end

        // Reset with three operations in flight.
        @(posedge clk);
        #1;
        send(16'h0011, 16'h0022, 1'b0);
        send(16'h0033, 16'h0044, 1'b0);
        send(16'h0055, 16'h0066, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("midrst_sum",       {16'd0, sum},       32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        send(16'h0005, 16'h0003, 1'b0);
        check_latency("after_rst", 16'h0008, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        chk("model_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pipe_adder
